// File: rtl/tetron_collision_checker.sv
// Tetromino collision checker: tests four blocks against a synchronous board RAM, stopping at the first hit.
// done arrives 2 cycles per block examined (max 8); start is ignored while busy and is not queued.
module tetron_collision_checker #(
  parameter int BOARD_ROWS = 20,
  parameter int BOARD_COLS = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [4:0] origin_row,
  input  logic [4:0] origin_col,
  input  logic [4:0] blk1_voffset,
  input  logic [4:0] blk1_hoffset,
  input  logic [4:0] blk2_voffset,
  input  logic [4:0] blk2_hoffset,
  input  logic [4:0] blk3_voffset,
  input  logic [4:0] blk3_hoffset,
  input  logic [4:0] blk4_voffset,
  input  logic [4:0] blk4_hoffset,
  output logic       board_rd_en,
  output logic [4:0] board_rd_row,
  output logic [3:0] board_rd_col,
  input  logic       board_rd_data,
  output logic       busy,
  output logic       done,
  output logic       collision
);

  typedef enum logic [1:0] {IDLE, ISSUE, CHECK} state_t;

  localparam logic signed [6:0] ROWS_S = 7'(BOARD_ROWS);
  localparam logic signed [6:0] COLS_S = 7'(BOARD_COLS);

  state_t            state_q, state_d;
  logic [1:0]        k_q, k_d;
  logic [4:0]        org_row_q, org_row_d;
  logic [4:0]        org_col_q, org_col_d;
  logic [3:0][4:0]   voff_q, voff_d;
  logic [3:0][4:0]   hoff_q, hoff_d;
  logic              done_q, done_d;
  logic              coll_q, coll_d;

  logic signed [6:0] pos_row;
  logic signed [6:0] pos_col;
  logic              oob;

  // Position of the block selected by k; 7-bit signed so no offset can wrap.
  always_comb begin
    pos_row = $signed({2'b00, org_row_q}) + $signed({{2{voff_q[k_q][4]}}, voff_q[k_q]});
    pos_col = $signed({2'b00, org_col_q}) + $signed({{2{hoff_q[k_q][4]}}, hoff_q[k_q]});
    oob     = pos_row[6] || (pos_row >= ROWS_S) || pos_col[6] || (pos_col >= COLS_S);
  end

  always_comb begin
    board_rd_en  = (state_q == ISSUE) && !oob;
    board_rd_row = board_rd_en ? pos_row[4:0] : 5'd0;
    board_rd_col = board_rd_en ? pos_col[3:0] : 4'd0;
    busy         = (state_q != IDLE);
    done         = done_q;
    collision    = coll_q;
  end

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    org_row_d = org_row_q;
    org_col_d = org_col_q;
    voff_d    = voff_q;
    hoff_d    = hoff_q;
    done_d    = 1'b0;
    coll_d    = coll_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = ISSUE;
          k_d       = 2'd0;
          org_row_d = origin_row;
          org_col_d = origin_col;
          voff_d    = {blk4_voffset, blk3_voffset, blk2_voffset, blk1_voffset};
          hoff_d    = {blk4_hoffset, blk3_hoffset, blk2_hoffset, blk1_hoffset};
          coll_d    = 1'b0;
        end
      end
      ISSUE: state_d = CHECK;
      CHECK: begin
        // Out-of-bounds blocks never issued a read, so board_rd_data is irrelevant for them.
        if (oob || board_rd_data) begin
          state_d = IDLE;
          done_d  = 1'b1;
          coll_d  = 1'b1;
        end else if (k_q == 2'd3) begin
          state_d = IDLE;
          done_d  = 1'b1;
          coll_d  = 1'b0;
        end else begin
          state_d = ISSUE;
          k_d     = k_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      k_q       <= 2'd0;
      org_row_q <= 5'd0;
      org_col_q <= 5'd0;
      voff_q    <= '0;
      hoff_q    <= '0;
      done_q    <= 1'b0;
      coll_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      org_row_q <= org_row_d;
      org_col_q <= org_col_d;
      voff_q    <= voff_d;
      hoff_q    <= hoff_d;
      done_q    <= done_d;
      coll_q    <= coll_d;
    end
  end

endmodule

// File: tb/tb_tetron_collision_checker.sv
// Directed bench for tetron_collision_checker with a behavioural one-cycle board RAM.
module tb_tetron_collision_checker;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [4:0] origin_row, origin_col;
  logic [4:0] blk1_voffset, blk1_hoffset, blk2_voffset, blk2_hoffset;
  logic [4:0] blk3_voffset, blk3_hoffset, blk4_voffset, blk4_hoffset;
  logic       board_rd_en;
  logic [4:0] board_rd_row;
  logic [3:0] board_rd_col;
  logic       board_rd_data;
  logic       busy, done, collision;

  logic       board [0:31][0:15];
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  tetron_collision_checker #(.BOARD_ROWS(20), .BOARD_COLS(10)) dut (
    .clk(clk), .reset(reset), .start(start),
    .origin_row(origin_row), .origin_col(origin_col),
    .blk1_voffset(blk1_voffset), .blk1_hoffset(blk1_hoffset),
    .blk2_voffset(blk2_voffset), .blk2_hoffset(blk2_hoffset),
    .blk3_voffset(blk3_voffset), .blk3_hoffset(blk3_hoffset),
    .blk4_voffset(blk4_voffset), .blk4_hoffset(blk4_hoffset),
    .board_rd_en(board_rd_en), .board_rd_row(board_rd_row), .board_rd_col(board_rd_col),
    .board_rd_data(board_rd_data),
    .busy(busy), .done(done), .collision(collision)
  );

  always @(posedge clk)
    board_rd_data <= board_rd_en ? board[board_rd_row][board_rd_col] : 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [4:0] r, input logic [4:0] c,
                        input logic [3:0][4:0] v, input logic [3:0][4:0] h);
    origin_row   = r;    origin_col   = c;
    blk1_voffset = v[0]; blk1_hoffset = h[0];
    blk2_voffset = v[1]; blk2_hoffset = h[1];
    blk3_voffset = v[2]; blk3_hoffset = h[2];
    blk4_voffset = v[3]; blk4_hoffset = h[3];
  endtask

  task automatic scramble();
    set_in(5'd0, 5'd0, {4{5'h10}}, {4{5'h10}});
  endtask

  // Call at a negedge. exp_rd[i] = {row, col} of the i-th expected read.
  task automatic run_check(input string name,
                           input logic [4:0] r, input logic [4:0] c,
                           input logic [3:0][4:0] v, input logic [3:0][4:0] h,
                           input int exp_done, input logic exp_coll,
                           input int exp_nrd, input logic [3:0][8:0] exp_rd,
                           input int ign_edge);
    logic [8:0] rd_log[$];
    int done_at = 0;
    int ndone = 0;
    int addr_bad = 0;
    logic coll_at = 1'bx;
    set_in(r, c, v, h);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    scramble();
    chk({name, ":busy"}, busy, 1);
    chk({name, ":coll_clr"}, collision, 0);
    for (int n = 0; n < 20; n++) begin
      if (n > 0) @(negedge clk);
      start = (ign_edge > 0 && n == ign_edge - 1);
      if (board_rd_en) rd_log.push_back({board_rd_row, board_rd_col});
      else if (board_rd_row != 5'd0 || board_rd_col != 4'd0) addr_bad++;
      if (done) begin
        if (ndone == 0) begin done_at = n; coll_at = collision; end
        ndone++;
      end
    end
    start = 1'b0;
    chk({name, ":done_edge"}, done_at, exp_done);
    chk({name, ":ndone"}, ndone, 1);
    chk({name, ":collision"}, coll_at, exp_coll);
    chk({name, ":nreads"}, rd_log.size(), exp_nrd);
    chk({name, ":idle_addr"}, addr_bad, 0);
    for (int i = 0; i < exp_nrd && i < rd_log.size(); i++)
      chk($sformatf("%s:rd%0d", name, i + 1), rd_log[i], exp_rd[i]);
  endtask

  initial begin
    int n;
    logic seen;
    for (int i = 0; i < 32; i++)
      for (int j = 0; j < 16; j++) board[i][j] = 1'b0;
    reset = 1'b1;
    start = 1'b0;
    scramble();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst:busy", busy, 0);
    chk("rst:done", done, 0);
    chk("rst:coll", collision, 0);
    chk("rst:rd_en", board_rd_en, 0);
    reset = 1'b0;
    @(negedge clk);

    // Empty board, four in-bounds blocks.
    run_check("t1", 5'd10, 5'd5, {5'd1, 5'd0, 5'h1f, 5'd0}, {5'h1f, 5'h1f, 5'd0, 5'd0},
              8, 1'b0, 4, {{5'd11, 4'd4}, {5'd10, 4'd4}, {5'd9, 4'd5}, {5'd10, 4'd5}}, 0);
    // Block 2 hits an occupied cell.
    board[9][5] = 1'b1;
    run_check("t2", 5'd10, 5'd5, {5'd1, 5'd0, 5'h1f, 5'd0}, {5'h1f, 5'h1f, 5'd0, 5'd0},
              4, 1'b1, 2, {{9'd0}, {9'd0}, {5'd9, 4'd5}, {5'd10, 4'd5}}, 0);
    board[9][5] = 1'b0;
    // Block 3 at column -1.
    run_check("t3", 5'd10, 5'd0, {5'd0, 5'd0, 5'd1, 5'd0}, {5'd1, 5'h1f, 5'd0, 5'd0},
              6, 1'b1, 2, {{9'd0}, {9'd0}, {5'd11, 4'd0}, {5'd10, 4'd0}}, 0);
    // Block 4 at row 20.
    run_check("t4", 5'd19, 5'd5, {5'd1, 5'd0, 5'd0, 5'd0}, {5'd0, 5'h1f, 5'd1, 5'd0},
              8, 1'b1, 3, {{9'd0}, {5'd19, 4'd4}, {5'd19, 4'd6}, {5'd19, 4'd5}}, 0);
    // Block 1 at row -16: no read at all.
    run_check("t5", 5'd0, 5'd0, {5'd0, 5'd0, 5'd0, 5'h10}, {5'd0, 5'd0, 5'd0, 5'd0},
              2, 1'b1, 0, {4{9'd0}}, 0);
    // Duplicate positions at the far corner, each read separately.
    run_check("t6", 5'd19, 5'd9, {4{5'd0}}, {4{5'd0}},
              8, 1'b0, 4, {4{{5'd19, 4'd9}}}, 0);
    // Last block hits cell (0,0).
    board[0][0] = 1'b1;
    run_check("t7", 5'd1, 5'd1, {5'h1f, 5'd0, 5'd1, 5'd0}, {5'h1f, 5'd1, 5'd0, 5'd0},
              8, 1'b1, 4, {{5'd0, 4'd0}, {5'd1, 4'd2}, {5'd2, 4'd1}, {5'd1, 4'd1}}, 0);
    board[0][0] = 1'b0;
    // start pulsed at E3 during a check is ignored.
    run_check("t8", 5'd10, 5'd5, {5'd1, 5'd0, 5'h1f, 5'd0}, {5'h1f, 5'h1f, 5'd0, 5'd0},
              8, 1'b0, 4, {{5'd11, 4'd4}, {5'd10, 4'd4}, {5'd9, 4'd5}, {5'd10, 4'd5}}, 3);

    // start in the done cycle is accepted and clears collision.
    board[9][5] = 1'b1;
    set_in(5'd10, 5'd5, {5'd1, 5'd0, 5'h1f, 5'd0}, {5'h1f, 5'h1f, 5'd0, 5'd0});
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      if (done) seen = 1'b1;
      else begin @(negedge clk); n++; end
    end
    chk("b2b:first_done", n, 4);
    chk("b2b:first_coll", collision, 1);
    board[9][5] = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("b2b:coll_cleared", collision, 0);
    chk("b2b:busy", busy, 1);
    chk("b2b:done_low", done, 0);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      if (done) seen = 1'b1;
      else begin @(negedge clk); n++; end
    end
    chk("b2b:second_done", n, 8);
    chk("b2b:second_coll", collision, 0);
    @(negedge clk);

    // Reset sampled at E3 aborts the check silently.
    set_in(5'd10, 5'd5, {5'd1, 5'd0, 5'h1f, 5'd0}, {5'h1f, 5'h1f, 5'd0, 5'd0});
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mrst:busy", busy, 0);
    chk("mrst:done", done, 0);
    chk("mrst:coll", collision, 0);
    chk("mrst:addr", {board_rd_en, board_rd_row, board_rd_col}, 0);
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) n++;
    end
    chk("mrst:no_done", n, 0);
    run_check("t9", 5'd10, 5'd5, {5'd1, 5'd0, 5'h1f, 5'd0}, {5'h1f, 5'h1f, 5'd0, 5'd0},
              8, 1'b0, 4, {{5'd11, 4'd4}, {5'd10, 4'd4}, {5'd9, 4'd5}, {5'd10, 4'd5}}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
